// File: rtl/regfile_cmd_master_if.sv
// Command, register-file pin and response bundle of regfile_cmd_master.
// The master modport is the engine side; the slave modport is the host plus register file.
`timescale 1ns/1ps
interface regfile_cmd_master_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_waddr;
    logic [WIDTH-1:0]  cmd_wdata;
    logic [ADDR_W-1:0] cmd_raddr1;
    logic [ADDR_W-1:0] cmd_raddr2;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [WIDTH-1:0]  rf_wdata;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [WIDTH-1:0]  rf_rdata1;
    logic [WIDTH-1:0]  rf_rdata2;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data1;
    logic [WIDTH-1:0]  rsp_data2;
    logic              rsp_err;

    logic              busy;
    logic [7:0]        err_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_waddr, cmd_wdata, cmd_raddr1, cmd_raddr2,
        output cmd_ready,
        output rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        output rsp_valid, rsp_data1, rsp_data2, rsp_err,
        input  rsp_ready,
        output busy, err_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_waddr, cmd_wdata, cmd_raddr1, cmd_raddr2,
        input  cmd_ready,
        input  rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        input  rsp_valid, rsp_data1, rsp_data2, rsp_err,
        output rsp_ready,
        input  busy, err_count
    );
endinterface

// File: rtl/regfile_cmd_master.sv
// Initiator engine sequencing writes, reads and write-readbacks on the 8-entry register file.
// Optional mismatch counter on err_count is enabled by defining REGSEQ_ERRCNT_EN.
`timescale 1ns/1ps
module regfile_cmd_master #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_cmd_master_if.master bus
);
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRB   = 2'b11;

    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    state_t            state;
    logic              wrb_q;
    logic [ADDR_W-1:0] rb_raddr2;
    logic              rb_mismatch;

    // Entry 0 ignores writes, so a readback of it must return zero.
    function automatic logic [WIDTH-1:0] readback_expect(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  data
    );
        return (addr == '0) ? '0 : data;
    endfunction

    assign rb_mismatch = (bus.rf_rdata1 != readback_expect(bus.rf_waddr, bus.rf_wdata));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wrb_q         <= 1'b0;
            rb_raddr2     <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.rf_raddr1 <= '0;
            bus.rf_raddr2 <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data1 <= '0;
            bus.rsp_data2 <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        case (bus.cmd_op)
                            OP_WRITE, OP_WRB: begin
                                state         <= WR;
                                wrb_q         <= (bus.cmd_op == OP_WRB);
                                rb_raddr2     <= bus.cmd_raddr2;
                                bus.rf_we     <= 1'b1;
                                bus.rf_waddr  <= bus.cmd_waddr;
                                bus.rf_wdata  <= bus.cmd_wdata;
                                bus.cmd_ready <= 1'b0;
                                bus.busy      <= 1'b1;
                            end
                            OP_READ: begin
                                state         <= RD;
                                wrb_q         <= 1'b0;
                                bus.rf_raddr1 <= bus.cmd_raddr1;
                                bus.rf_raddr2 <= bus.cmd_raddr2;
                                bus.cmd_ready <= 1'b0;
                                bus.busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                WR: begin
                    bus.rf_we <= 1'b0;
                    if (wrb_q) begin
                        state         <= RD;
                        bus.rf_raddr1 <= bus.rf_waddr;
                        bus.rf_raddr2 <= rb_raddr2;
                    end else begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                RD: begin
                    state         <= RSP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data1 <= bus.rf_rdata1;
                    bus.rsp_data2 <= bus.rf_rdata2;
                    bus.rsp_err   <= wrb_q && rb_mismatch;
                end
                RSP: begin
                    // The handshake cycle keeps cmd_ready low; accepting resumes next cycle.
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef REGSEQ_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (state == RD && wrb_q && rb_mismatch && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.err_count = err_cnt;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed and randomized bench for regfile_cmd_master with an attached register-file model.
`timescale 1ns/1ps
module tb_regfile_cmd_master;
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRB   = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic fault_en = 1'b0;
    int   ref_errs = 0;
    logic [3:0] ref_mem [8];
    logic [3:0] rf_mem [8] = '{default: 4'h0};

    regfile_cmd_master_if #(.WIDTH(4), .ADDR_W(3)) bus ();

    regfile_cmd_master #(.WIDTH(4), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read, entry 0 reads zero.
    always @(posedge clk) begin
        if (bus.rf_we && bus.rf_waddr != 3'd0) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata1 = (fault_en && bus.rf_raddr1 == 3'd5) ? 4'h5 :
                           (bus.rf_raddr1 == 3'd0) ? 4'h0 : rf_mem[bus.rf_raddr1];
    assign bus.rf_rdata2 = (bus.rf_raddr2 == 3'd0) ? 4'h0 : rf_mem[bus.rf_raddr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_rd1(input logic [2:0] a);
        return (fault_en && a == 3'd5) ? 4'h5 : ref_mem[a];
    endfunction

    function automatic logic [7:0] exp_err_count();
`ifdef REGSEQ_ERRCNT_EN
        return 8'(ref_errs);
`else
        return 8'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] wa, input logic [3:0] wd,
                         input logic [2:0] r1, input logic [2:0] r2);
        bus.cmd_op     = op;
        bus.cmd_waddr  = wa;
        bus.cmd_wdata  = wd;
        bus.cmd_raddr1 = r1;
        bus.cmd_raddr2 = r2;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic finish_rsp(input logic [3:0] e1, input logic [3:0] e2, input logic eerr,
                              input int stall, input bit hold_valid);
        check("rsp_valid_on", 32'(bus.rsp_valid), 32'd1);
        check("rsp_data1", 32'(bus.rsp_data1), 32'(e1));
        check("rsp_data2", 32'(bus.rsp_data2), 32'(e2));
        check("rsp_err", 32'(bus.rsp_err), 32'(eerr));
        for (int i = 0; i < stall; i++) begin
            if (hold_valid) drive(OP_READ, 3'd1, 4'h3, 3'd2, 3'd4);
            step();
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_data1", 32'(bus.rsp_data1), 32'(e1));
            check("stall_data2", 32'(bus.rsp_data2), 32'(e2));
            check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("rsp_done", 32'(bus.rsp_valid), 32'd0);
        check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("err_count", 32'(bus.err_count), 32'(exp_err_count()));
    endtask

    // Reference behaviour: a command updates the abstract memory, then the expected
    // pin activity and response are checked cycle by cycle from the accept edge.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] wa, input logic [3:0] wd,
                           input logic [2:0] r1, input logic [2:0] r2,
                           input int stall, input bit hold_valid);
        logic [3:0] e1, e2;
        logic eerr;
        e1 = 4'h0; e2 = 4'h0; eerr = 1'b0;
        if ((op == OP_WRITE || op == OP_WRB) && wa != 3'd0) ref_mem[wa] = wd;
        if (op == OP_READ) begin
            e1 = model_rd1(r1);
            e2 = ref_mem[r2];
        end else if (op == OP_WRB) begin
            e1 = model_rd1(wa);
            e2 = ref_mem[r2];
            eerr = (e1 != ((wa == 3'd0) ? 4'h0 : wd));
            if (eerr && ref_errs < 255) ref_errs++;
        end
        wait_ready();
        drive(op, wa, wd, r1, r2);
        step();
        bus.cmd_valid = 1'b0;
        case (op)
            OP_NOP: begin
                check("nop_ready", 32'(bus.cmd_ready), 32'd1);
                check("nop_we", 32'(bus.rf_we), 32'd0);
            end
            OP_WRITE: begin
                check("wr_we", 32'(bus.rf_we), 32'd1);
                check("wr_waddr", 32'(bus.rf_waddr), 32'(wa));
                check("wr_wdata", 32'(bus.rf_wdata), 32'(wd));
                check("wr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
                step();
                check("wr_we_off", 32'(bus.rf_we), 32'd0);
                check("wr_ready_back", 32'(bus.cmd_ready), 32'd1);
                check("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
            end
            OP_READ: begin
                check("rd_no_we", 32'(bus.rf_we), 32'd0);
                check("rd_rsp_early", 32'(bus.rsp_valid), 32'd0);
                check("rd_busy", 32'(bus.busy), 32'd1);
                step();
                finish_rsp(e1, e2, eerr, stall, hold_valid);
            end
            default: begin
                check("wrb_we", 32'(bus.rf_we), 32'd1);
                check("wrb_waddr", 32'(bus.rf_waddr), 32'(wa));
                step();
                check("wrb_we_off", 32'(bus.rf_we), 32'd0);
                check("wrb_raddr1", 32'(bus.rf_raddr1), 32'(wa));
                check("wrb_raddr2", 32'(bus.rf_raddr2), 32'(r2));
                check("wrb_rsp_early", 32'(bus.rsp_valid), 32'd0);
                step();
                finish_rsp(e1, e2, eerr, stall, hold_valid);
            end
        endcase
    endtask

    initial begin
        int n;
        logic [3:0] old6;
        for (int i = 0; i < 8; i++) ref_mem[i] = 4'h0;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_NOP; bus.cmd_waddr = 3'd0; bus.cmd_wdata = 4'h0;
        bus.cmd_raddr1 = 3'd0; bus.cmd_raddr2 = 3'd0; bus.rsp_ready = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        run_cmd(OP_WRITE, 3'd3, 4'hA, 3'd0, 3'd0, 0, 1'b0);
        run_cmd(OP_READ, 3'd0, 4'h0, 3'd3, 3'd0, 1, 1'b0);
        run_cmd(OP_WRB, 3'd0, 4'hF, 3'd0, 3'd3, 0, 1'b0);
        fault_en = 1'b1;
        run_cmd(OP_WRB, 3'd5, 4'h6, 3'd0, 3'd3, 0, 1'b0);
        fault_en = 1'b0;
        run_cmd(OP_READ, 3'd0, 4'h0, 3'd5, 3'd3, 5, 1'b1);

        // Reset during WR: the write strobe must drop asynchronously and nothing follows.
        old6 = ref_mem[6];
        wait_ready();
        drive(OP_WRITE, 3'd6, 4'h7, 3'd0, 3'd0);
        step();
        bus.cmd_valid = 1'b0;
        check("abort_we_before", 32'(bus.rf_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_we_async", 32'(bus.rf_we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        ref_errs = 0;
        check("abort_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        run_cmd(OP_READ, 3'd0, 4'h0, 3'd6, 3'd3, 0, 1'b0);
        check("abort_no_write", 32'(rf_mem[6]), 32'(old6));

        // Back-to-back NOP, READ, WRITE with cmd_valid held high throughout.
        wait_ready();
        drive(OP_NOP, 3'd0, 4'h0, 3'd0, 3'd0);
        step();
        check("b2b_nop_ready", 32'(bus.cmd_ready), 32'd1);
        drive(OP_READ, 3'd0, 4'h0, 3'd3, 3'd5);
        step();
        check("b2b_rd_busy", 32'(bus.busy), 32'd1);
        drive(OP_WRITE, 3'd2, 4'h9, 3'd0, 3'd0);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_rsp_data1", 32'(bus.rsp_data1), 32'(ref_mem[3]));
        check("b2b_rsp_data2", 32'(bus.rsp_data2), 32'(ref_mem[5]));
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("b2b_ready_after", 32'(bus.cmd_ready), 32'd1);
        check("b2b_we_not_yet", 32'(bus.rf_we), 32'd0);
        step();
        bus.cmd_valid = 1'b0;
        ref_mem[2] = 4'h9;
        check("b2b_wr_we", 32'(bus.rf_we), 32'd1);
        check("b2b_wr_waddr", 32'(bus.rf_waddr), 32'd2);
        check("b2b_wr_wdata", 32'(bus.rf_wdata), 32'h9);
        step();

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        fault_en = 1'b1;
        run_cmd(OP_WRB, 3'd5, 4'hC, 3'd0, 3'd1, 0, 1'b0);
        fault_en = 1'b0;
        step();

        for (int i = 0; i < 8; i++) check("final_mem", 32'(rf_mem[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
